// File: rtl/vga_fb_pkg.sv
// Shared timing constants, types and helpers for the 640x480@60 framebuffer scan-out path.
// Optional build macro VGA_FB_SCAN_TEST_PATTERN_EN selects the colour-bar generator in vga_fb_scan.
package vga_fb_pkg;
  localparam int CNT_W = 10;
  localparam int FB_AW = 14;

  localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [CNT_W-1:0] H_FP     = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
  localparam logic [CNT_W-1:0] H_BP     = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [CNT_W-1:0] V_FP     = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
  localparam logic [CNT_W-1:0] V_BP     = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HS_BEGIN = H_ACTIVE + H_FP;
  localparam logic [CNT_W-1:0] HS_END   = HS_BEGIN + H_SYNC;
  localparam logic [CNT_W-1:0] VS_BEGIN = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] VS_END   = VS_BEGIN + V_SYNC;

  localparam logic [FB_AW-1:0] WORDS_PER_LINE = FB_AW'(H_ACTIVE >> 5);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Per-pixel control travelling alongside the framebuffer read latency.
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic fs;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

  // 80-pixel bar index without a divider.
  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] h);
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (h >= CNT_W'(i * 80)) bar_idx = 3'(i);
  endfunction
endpackage

// File: rtl/vga_timing_cnt.sv
// Raster position counters, active flag, raw (unaligned) syncs and the per-line
// framebuffer base address, accumulated so no multiplier is needed.
module vga_timing_cnt
  import vga_fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_n_o,
  output logic             vsync_n_o,
  output logic [FB_AW-1:0] line_base_o
);
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [FB_AW-1:0] line_base_q, line_base_d;
  logic             h_end, v_end;

  assign h_end = (h_cnt_q == H_TOTAL - 10'd1);
  assign v_end = (v_cnt_q == V_TOTAL - 10'd1);

  always_comb begin
    h_cnt_d     = h_end ? '0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    if (h_end) begin
      v_cnt_d = v_end ? '0 : v_cnt_q + 10'd1;
      if (v_end)                   line_base_d = '0;
      else if (v_cnt_q < V_ACTIVE) line_base_d = line_base_q + WORDS_PER_LINE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign line_base_o = line_base_q;
  assign active_o    = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
  assign hsync_n_o   = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
  assign vsync_n_o   = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
endmodule

// File: rtl/vga_fb_scan.sv
// 1bpp framebuffer scan-out: fetch, pixel shift register, sync alignment pipe and colour mux.
// Define VGA_FB_SCAN_TEST_PATTERN_EN to replace framebuffer pixels with 8 colour bars.
module vga_fb_scan
  import vga_fb_pkg::*;
#(
  parameter int          RD_LAT   = 1,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic             Clock,
  input  logic             Rst_N,
  output logic             FB_RdEn,
  output logic [FB_AW-1:0] FB_RdAddr,
  input  logic [31:0]      FB_RdData,
  output logic [3:0]       RED,
  output logic [3:0]       GREEN,
  output logic [3:0]       BLUE,
  output logic             h_sync,
  output logic             v_sync,
  output logic             Frame_Start
);
  localparam int STAGES = RD_LAT + 1;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [FB_AW-1:0] line_base;
  logic             active, hs_n, vs_n;
  vid_ctl_t         ctl_in, ctl_out;
  vid_ctl_t [STAGES:1] ctl_q;
  rgb12_t           pix;

  vga_timing_cnt u_cnt (
    .clk_i       (Clock),
    .rst_ni      (Rst_N),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_n_o   (hs_n),
    .vsync_n_o   (vs_n),
    .line_base_o (line_base)
  );

  assign FB_RdAddr = line_base + FB_AW'(h_cnt[9:5]);

  assign ctl_in = '{active: active, hs_n: hs_n, vs_n: vs_n,
                    fs: (h_cnt == '0) && (v_cnt == '0)};

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      ctl_q <= {STAGES{CTL_IDLE}};
    end else begin
      ctl_q[1] <= ctl_in;
      for (int i = 2; i <= STAGES; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  assign ctl_out     = ctl_q[STAGES];
  assign h_sync      = ctl_out.hs_n;
  assign v_sync      = ctl_out.vs_n;
  assign Frame_Start = ctl_out.fs;

`ifdef VGA_FB_SCAN_TEST_PATTERN_EN
  logic [STAGES:1][2:0] bar_q;

  assign FB_RdEn = 1'b0;

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      bar_q <= '0;
    end else begin
      bar_q[1] <= bar_idx(h_cnt);
      for (int i = 2; i <= STAGES; i++) bar_q[i] <= bar_q[i-1];
    end
  end

  assign pix = ctl_out.active ? rgb12_t'({{4{bar_q[STAGES][2]}}, {4{bar_q[STAGES][1]}},
                                          {4{bar_q[STAGES][0]}}})
                              : '0;
`else
  logic [RD_LAT:1] fetch_q;
  logic [31:0]     sr_q, sr_d;

  // Gated by reset so the strobe drops the instant reset asserts mid-line.
  assign FB_RdEn = Rst_N && active && (h_cnt[4:0] == 5'd0);

  always_comb begin
    sr_d = {1'b0, sr_q[31:1]};
    if (fetch_q[RD_LAT]) sr_d = FB_RdData;
  end

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      fetch_q <= '0;
      sr_q    <= '0;
    end else begin
      fetch_q[1] <= FB_RdEn;
      for (int i = 2; i <= RD_LAT; i++) fetch_q[i] <= fetch_q[i-1];
      sr_q <= sr_d;
    end
  end

  assign pix = ctl_out.active ? rgb12_t'(sr_q[0] ? FG_COLOR : BG_COLOR) : '0;
`endif

  assign RED   = pix.r;
  assign GREEN = pix.g;
  assign BLUE  = pix.b;
endmodule

// File: doc/vga_fb_scan.md
# vga_fb_scan

Framebuffer scan-out engine for the FPGA VGA path. It runs on the 25 MHz pixel clock from the PLL and generates 640x480@60 timing. It reads a 1-bit-per-pixel framebuffer through a fixed-latency synchronous read port and drives the board's 4-bit RGB pins plus h_sync/v_sync. It is the stage directly downstream of the core's video memory.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (V_TOTAL = 525)
- RD_LAT, 1, framebuffer read latency in cycles; legal values are 1 and 2
- FG_COLOR, 12'hFFF, {R,G,B} colour for pixel bit 1
- BG_COLOR, 12'h000, {R,G,B} colour for pixel bit 0
- Clock  in  1  pixel clock, 25 MHz
- Rst_N  in  1  asynchronous, active-low reset
- FB_RdEn  out  1  framebuffer read strobe
- FB_RdAddr  out  14  word address; one 32-bit word holds 32 pixels
- FB_RdData  in  32  read data, valid RD_LAT cycles after FB_RdEn
- RED / GREEN / BLUE  out  4 each  pixel colour
- h_sync  out  1  active-low
- v_sync  out  1  active-low
- Frame_Start  out  1  one-cycle pulse coincident with pixel (0,0) on the output pins

## Operation
- Counters: h_cnt runs 0..H_TOTAL-1. It wraps to 0 and increments v_cnt, which runs 0..V_TOTAL-1 and wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync assertion:
  - h_sync is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), which is [656,752).
  - v_sync is low for v_cnt in [490,492).
- Framebuffer addressing:
  - WORDS_PER_LINE = H_ACTIVE/32 = 20.
  - line_base is a register cleared at v_cnt wrap and advanced by 20 at the end of each active line. No multiplier is used.
  - FB_RdAddr = line_base + h_cnt[9:5].
- Fetch: FB_RdEn is asserted for one cycle when the position is active and h_cnt[4:0]==0. That gives 20 reads per active line and 9600 per frame, covering addresses 0..9599.
- Pixel mapping:
  - On data return, FB_RdData loads a 32-bit shift register. Pixel x uses bit x[4:0], so the LSB is the leftmost pixel.
  - The register shifts right once per pixel.
  - Bit 1 selects FG_COLOR; bit 0 selects BG_COLOR.
- Blanking: outside the active region RGB is 0, regardless of the shift register contents.
- Alignment: active, h_sync, v_sync and Frame_Start pass through a delay pipe of RD_LAT+1 stages, so sync edges align with the pixels they belong to.

## Timing
- Reset: while Rst_N is low, all counters, the pipe and line_base are 0. Outputs take these values:
  - h_sync = 1, v_sync = 1
  - RED/GREEN/BLUE = 0
  - FB_RdEn = 0, FB_RdAddr = 0
  - Frame_Start = 0
- First cycle after reset release: h_cnt=v_cnt=0, FB_RdEn=1, FB_RdAddr=0.
- Latency: counter position to pins is RD_LAT+1 cycles. Frame_Start is high RD_LAT+1 cycles after the first rising edge following reset release.
- Line wrap: the cycle after h_cnt=799 has h_cnt=0 and v_cnt+1. v_cnt=524 wraps to 0 together with line_base.
- Reset mid-frame: takes effect immediately and asynchronously. Pending pipe data is discarded, and the first frame after release starts cleanly at (0,0).
- FB_RdData is sampled exactly RD_LAT cycles after FB_RdEn. There is no backpressure, and the memory must meet this latency.

## Configuration
- VGA_FB_SCAN_TEST_PATTERN_EN defined:
  - The FB port is unused; FB_RdEn is held at 0.
  - Active pixels show 8 vertical bars, each 80 pixels wide. The bar index b = h/80, and the colour is {4{b[2]}}, {4{b[1]}}, {4{b[0]}} for R,G,B.
  - Sync and alignment are unchanged.
- Undefined: normal framebuffer scan-out as described above.

## Structure
- Package vga_fb_pkg holds:
  - the timing constants and H_TOTAL/V_TOTAL
  - WORDS_PER_LINE
  - typedef rgb12_t (packed {r,g,b} of 4 bits each)
  - FB address width (14)
- Sub-module vga_timing_cnt contains h_cnt/v_cnt, the active flag, raw syncs and line_base. vga_fb_scan adds fetch, shift register, delay pipe and colour mux.

## Test plan
- Reset held then released → outputs take their reset values during reset; FB_RdEn=1 with addr 0 on the first cycle after release; Frame_Start at cycle RD_LAT+1.
- Free-run 2 frames → h_sync period 800 with 96 low cycles; v_sync period 420000 cycles with 1600 low cycles; sync edges offset from counters by RD_LAT+1.
- Address trace over one frame → 9600 reads, strictly incrementing 0..9599. Line 1 starts at addr 20 with h_cnt=0. No reads during blanking.
- Memory model returning word0=32'h0000_0001, RD_LAT=2 → pixel (0,0)=FG 12'hFFF and pixels 1..31 = BG on the pins; repeat with RD_LAT=1.
- Rst_N pulsed low at v_cnt=200, h_cnt=300 → outputs go to reset values immediately; next frame begins at addr 0.
- Build with VGA_FB_SCAN_TEST_PATTERN_EN → FB_RdEn never high. Pixel 0 is 12'h000, pixel 80 is 12'h00F, pixel 560 is 12'hFFF, and pixel 640 is blanked to 0.
